// File: rtl/serial_addsub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock, start/done handshake.
// Define SERIAL_ADDSUB_OVERFLOW_EN to drive ovf with signed overflow; otherwise ovf is tied to 0.
module serial_addsub_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;

  logic bit_s;
  logic c_next;

`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  localparam logic [CW-1:0] MsbCnt = CW'(WIDTH - 2);
  logic c_msb_q;
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Full-adder / full-subtractor cell on the current LSBs.
  always_comb begin
    bit_s = a_q[0] ^ b_q[0] ^ c_q;
    if (op_q) begin
      c_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & c_q);
    end else begin
      c_next = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & c_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
      c_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            busy    <= 1'b1;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
            c_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
            state_q <= StShift;
          end
        end
        StShift: begin
          result <= {bit_s, result[WIDTH-1:1]};
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          c_q    <= c_next;
          cnt_q  <= cnt_q + 1'b1;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
          // Carry/borrow entering the MSB cell.
          if (cnt_q == MsbCnt) begin
            c_msb_q <= c_next;
          end
`endif
          if (cnt_q == LastCnt) begin
            cout    <= c_next;
            busy    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
            ovf_q   <= c_msb_q ^ c_next;
`endif
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Randomized self-checking bench for serial_addsub_unit (WIDTH=8) against an arithmetic model.
module tb_serial_addsub_unit;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  serial_addsub_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on integers.
  function automatic logic [WIDTH+1:0] model(input bit o, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    int unsigned full;
    logic [WIDTH-1:0] r;
    logic c, v;
    if (o) begin
      full = (int'(x) - int'(y)) & 32'hFF;
      c    = (x < y);
    end else begin
      full = int'(x) + int'(y);
      c    = (full > 255);
    end
    r = full[WIDTH-1:0];
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    if (o) v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    else   v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
`else
    v = 1'b0;
`endif
    return {v, c, r};
  endfunction

  // Launch one op and check handshake timing plus results; optionally poke start mid-shift.
  task automatic do_op(input bit o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input bit poke);
    logic [WIDTH+1:0] exp;
    int done_at;
    int busy_cnt;
    int extra_done;
    exp = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); op = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    done_at = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      if (poke) begin
        start = (j == 3);
        if (j == 3) begin a = 8'hAA; b = 8'h55; op = 1'b1; end
      end
      if (done) begin
        done_at = j;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check_eq("done_latency", done_at, 9);
    check_eq("busy_cycles", busy_cnt, WIDTH);
    check_eq("result", result, exp[WIDTH-1:0]);
    check_eq("cout", cout, exp[WIDTH]);
    check_eq("ovf", ovf, exp[WIDTH+1]);
    extra_done = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (j == 0) check_eq("result_hold", result, exp[WIDTH-1:0]);
    end
    check_eq("single_done", extra_done, 0);
  endtask

  initial begin
    #12;
    check_eq("reset_outs", {busy, done, result, cout, ovf}, '0);
    @(negedge clk); rst_n = 1'b1;

    do_op(1'b0, 8'h35, 8'h4A, 1'b0);
    do_op(1'b0, 8'hFF, 8'h01, 1'b0);
    do_op(1'b0, 8'hFF, 8'hFF, 1'b0);
    do_op(1'b1, 8'h10, 8'h01, 1'b0);
    do_op(1'b1, 8'h00, 8'h01, 1'b0);
    do_op(1'b0, 8'h01, 8'h02, 1'b1);
    do_op(1'b1, 8'h05, 8'h03, 1'b0);
    do_op(1'b0, 8'h7F, 8'h01, 1'b0);
    do_op(1'b1, 8'h80, 8'h01, 1'b0);

    // Asynchronous reset during the fourth shift cycle.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_eq("midop_reset", {busy, done, result, cout, ovf}, '0);
    begin
      int seen;
      seen = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (12) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      check_eq("no_done_after_reset", seen, 0);
    end
    do_op(1'b1, 8'h34, 8'h12, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_op(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
- Datapath core per bit: one full-adder cell (op=0) or full-subtractor cell (op=1), plus a registered carry/borrow flop.
- Wraps the combinational add/subtract cells as the sequential stage that consumes their per-bit outputs and drives them from operand shift registers.
- Start/done handshake to an upstream controller.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  1  0 = A+B, 1 = A-B; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse when result/cout are valid.
- result  output  WIDTH  sum or difference; held stable from done until the next accepted start.
- cout  output  1  final carry (op=0) or final borrow (op=1).
- ovf  output  1  signed overflow; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; operand registers, bit counter and carry flop all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge k
  - latches a, b, op; clears the carry flop and the counter; clears result; goes to SHIFT.
  - busy=1 from k onward.
- SHIFT: each cycle computes on A[0], B[0] and c.
  - Add: s = A0^B0^c; c' = A0&B0 | (A0^B0)&c.
  - Sub: d = A0^B0^c; c' = ~A0&B0 | ~(A0^B0)&c.
  - The result bit enters result MSB, and result shifts right.
  - A and B shift right with zero fill; c <= c'; counter increments.
  - After exactly WIDTH SHIFT cycles (counter==WIDTH-1 processed), go to DONE.
  - cout <= final c'.
- DONE (one cycle): done=1, busy=0; next state IDLE.
- Latency: start sampled at edge k → done high during cycle after edge k+WIDTH+1. For WIDTH=8, done is seen 9 edges after the start edge.
- Throughput: a new start is accepted in IDLE only. start during SHIFT or DONE is ignored with no effect on state. A start held high continuously launches back-to-back ops, each separated by the DONE cycle.
- a/b/op changes while busy have no effect (captured values only).
- result/cout/ovf are not updated after done until the next accepted start. result reads as shifting partial data while busy; consumers use it only at/after done.
- All arithmetic is modulo 2^WIDTH; cout reports the unsigned carry/borrow out of bit WIDTH-1.
- Reset asserted mid-operation aborts immediately; no done pulse; outputs return to reset values.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVERFLOW_EN
- Defined:
  - An extra flop captures the carry/borrow into the MSB, i.e. c before the final bit.
  - At the transition to DONE: ovf <= c_in_msb ^ c_out_msb. This is valid for both add and sub in two's complement.
  - ovf is held with result and cleared on the next accepted start.
- Undefined: port ovf still exists, tied constantly to 0; no extra flop.

Test Plan (WIDTH=8):
- Add, no carry: reset release, start op=0 a=0x35 b=0x4A.
  - busy=1 for 8 cycles, then done pulse at edge 9 after start.
  - result=0x7F, cout=0.
- Add with wrap: start op=0 a=0xFF b=0x01 → result=0x00, cout=1; a=0xFF b=0xFF → result=0xFE, cout=1.
- Subtract: op=1 a=0x10 b=0x01 → result=0x0F, cout=0; op=1 a=0x00 b=0x01 → result=0xFF, cout=1 (borrow).
- Busy protection: start op=0 a=0x01 b=0x02.
  - Pulse start with a=0xAA b=0x55 op=1 at cycle 3 of SHIFT.
  - Exactly one done; result=0x03, cout=0.
  - The next start in IDLE is accepted normally.
- Reset mid-op: start a=0x12 b=0x34; drop rst_n asynchronously at cycle 4 of SHIFT.
  - busy/done/result/cout/ovf go 0 immediately, with no done pulse.
  - After release, a new op completes correctly.
- Overflow (macro defined):
  - 0x7F+0x01 → result=0x80, ovf=1.
  - 0x80-0x01 → result=0x7F, ovf=1.
  - 0x05-0x03 → result=0x02, ovf=0.
  - Macro undefined: ovf=0 for all three.
